// File: rtl/btn_input_conditioner.sv
// btn_input_conditioner: multi-channel push-button / switch conditioner.
// Per channel: polarity normalise, 2-flop sync, stability-counter debounce,
// press/release ticks, hold-then-repeat auto-repeat ticks, and a sticky event bit.
// The top level ORs the enabled event bits into a registered interrupt.

// One conditioned channel. Its input is already polarity-normalised (1 = pressed).
module btn_input_conditioner_ch #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLD_CYCLES     = 25_000_000,
   parameter int REPEAT_CYCLES   = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_pressed,
   input  logic rpt_en,
   input  logic evt_clr,
   output logic level,
   output logic press_tick,
   output logic rel_tick,
   output logic rpt_tick,
   output logic evt
);

   localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int RCW  = $clog2(RMAX + 1);

   localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RCW-1:0] HOLD_LAST = RCW'(HOLD_CYCLES - 1);
   localparam logic [RCW-1:0] RPT_LAST  = RCW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, HOLD, RPT} rpt_state_t;

   logic           s1, s2;
   logic [DBW-1:0] db_cnt;
   logic           db_done, rise_now, fall_now;

   rpt_state_t     state_q, state_d;
   logic [RCW-1:0] rcnt_q, rcnt_d;
   logic           rpt_d;

   // The level flips on the edge where the synchronised sample has differed
   // for the full debounce window; the FSM needs this same-edge view.
   assign db_done  = (s2 != level) && (db_cnt == DB_LAST);
   assign rise_now = db_done & s2;
   assign fall_now = db_done & ~s2;

   // Synchroniser, stability counter, debounced level and edge ticks
   always_ff @(posedge clk) begin
      if (rst) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         db_cnt     <= '0;
         level      <= 1'b0;
         press_tick <= 1'b0;
         rel_tick   <= 1'b0;
      end else begin
         s1         <= raw_pressed;
         s2         <= s1;
         press_tick <= rise_now;
         rel_tick   <= fall_now;
         if (s2 == level) begin
            db_cnt <= '0;
         end else if (db_done) begin
            level  <= s2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DBW'(1);
         end
      end
   end

   // Repeat FSM next-state: arm on a press, wait HOLD, then tick every REPEAT;
   // a falling level or a dropped enable aborts without a final tick
   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      rpt_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise_now && rpt_en) begin
               state_d = HOLD;
               rcnt_d  = '0;
            end
         end
         HOLD: begin
            if (!rpt_en || fall_now) begin
               state_d = IDLE;
               rcnt_d  = '0;
            end else if (rcnt_q == HOLD_LAST) begin
               rpt_d   = 1'b1;
               state_d = RPT;
               rcnt_d  = '0;
            end else begin
               rcnt_d  = rcnt_q + RCW'(1);
            end
         end
         RPT: begin
            if (!rpt_en || fall_now) begin
               state_d = IDLE;
               rcnt_d  = '0;
            end else if (rcnt_q == RPT_LAST) begin
               rpt_d   = 1'b1;
               rcnt_d  = '0;
            end else begin
               rcnt_d  = rcnt_q + RCW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            rcnt_d  = '0;
         end
      endcase
   end

   // Repeat FSM state, counter and registered repeat tick
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rcnt_q   <= '0;
         rpt_tick <= 1'b0;
      end else begin
         state_q  <= state_d;
         rcnt_q   <= rcnt_d;
         rpt_tick <= rpt_d;
      end
   end

   // Sticky event: set by press/repeat tick, cleared by write-1; set wins
   always_ff @(posedge clk) begin
      if (rst) evt <= 1'b0;
      else     evt <= (evt & ~evt_clr) | press_tick | rpt_tick;
   end

endmodule

// Top: array of independent channels plus the shared interrupt register.
module btn_input_conditioner #(
   parameter int              N_CH            = 4,
   parameter int              DEBOUNCE_CYCLES = 1_000_000,
   parameter int              HOLD_CYCLES     = 25_000_000,
   parameter int              REPEAT_CYCLES   = 5_000_000,
   parameter logic [N_CH-1:0] ACTIVE_LOW      = '1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [N_CH-1:0] i_raw,
   input  logic [N_CH-1:0] i_rpt_en,
   input  logic [N_CH-1:0] i_irq_en,
   input  logic [N_CH-1:0] i_evt_clr,
   output logic [N_CH-1:0] o_level,
   output logic [N_CH-1:0] o_press,
   output logic [N_CH-1:0] o_release,
   output logic [N_CH-1:0] o_repeat,
   output logic [N_CH-1:0] o_event,
   output logic            o_irq
);

   logic [N_CH-1:0] pressed_raw;

   assign pressed_raw = i_raw ^ ACTIVE_LOW;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      btn_input_conditioner_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_ch (
         .clk         (i_clk),
         .rst         (i_rst),
         .raw_pressed (pressed_raw[c]),
         .rpt_en      (i_rpt_en[c]),
         .evt_clr     (i_evt_clr[c]),
         .level       (o_level[c]),
         .press_tick  (o_press[c]),
         .rel_tick    (o_release[c]),
         .rpt_tick    (o_repeat[c]),
         .evt         (o_event[c])
      );
   end

   // Interrupt is the registered OR of enabled sticky events
   always_ff @(posedge i_clk) begin
      if (i_rst) o_irq <= 1'b0;
      else       o_irq <= |(o_event & i_irq_en);
   end

endmodule

// File: tb/tb_btn_input_conditioner.sv
// Randomised + directed bench for btn_input_conditioner against a cycle-level
// behavioural model built from the debounce/repeat/event rules.
module tb_btn_input_conditioner;

   localparam int         NC  = 4;
   localparam int         DEB = 4;
   localparam int         HLD = 10;
   localparam int         RPC = 3;
   localparam logic [3:0] AL  = 4'b1111;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] raw, rpt_en, irq_en, evt_clr;
   logic [3:0] o_level, o_press, o_release, o_repeat, o_event;
   logic       o_irq;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   // model state
   logic [3:0] m_s1, m_s2, m_level, m_press, m_rel, m_rpt, m_evt;
   logic       m_irq;
   int         run   [NC];
   int         age   [NC];
   bit         armed [NC];

   btn_input_conditioner #(
      .N_CH(NC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HLD),
      .REPEAT_CYCLES(RPC), .ACTIVE_LOW(AL)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_raw(raw), .i_rpt_en(rpt_en),
      .i_irq_en(irq_en), .i_evt_clr(evt_clr), .o_level(o_level),
      .o_press(o_press), .o_release(o_release), .o_repeat(o_repeat),
      .o_event(o_event), .o_irq(o_irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s edge=%0d obs=%0h exp=%0h", tag, edge_n, obs, exp);
      end
   endtask

   // One clock edge of the reference: level follows the synchronised pin once it
   // has disagreed for DEB consecutive edges; repeats fall at press+HLD,
   // press+HLD+RPC, ... while still held and enabled.
   task automatic model_update();
      logic [3:0] n_lvl, n_press, n_rel, n_rpt, n_evt;
      logic       n_irq;
      edge_n++;
      if (rst) begin
         m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0; m_rel = 0;
         m_rpt = 0; m_evt = 0; m_irq = 0;
         for (int c = 0; c < NC; c++) begin run[c] = 0; age[c] = 0; armed[c] = 0; end
         return;
      end
      n_evt   = (m_evt & ~evt_clr) | m_press | m_rpt;
      n_irq   = |(m_evt & irq_en);
      n_lvl   = m_level;
      n_press = 0; n_rel = 0; n_rpt = 0;
      for (int c = 0; c < NC; c++) begin
         if (m_s2[c] != m_level[c]) begin
            run[c]++;
            if (run[c] == DEB) begin
               n_lvl[c]   = m_s2[c];
               n_press[c] = m_s2[c];
               n_rel[c]   = ~m_s2[c];
               run[c]     = 0;
            end
         end else begin
            run[c] = 0;
         end
         if (armed[c]) begin
            if (!rpt_en[c] || n_rel[c]) armed[c] = 0;
            else begin
               age[c]++;
               if (age[c] == HLD || (age[c] > HLD && (age[c] - HLD) % RPC == 0)) n_rpt[c] = 1;
            end
         end else if (n_press[c] && rpt_en[c]) begin
            armed[c] = 1;
            age[c]   = 0;
         end
      end
      m_s2 = m_s1; m_s1 = raw ^ AL;
      m_level = n_lvl; m_press = n_press; m_rel = n_rel; m_rpt = n_rpt;
      m_evt = n_evt; m_irq = n_irq;
   endtask

   task automatic compare();
      chk("level",   32'(o_level),   32'(m_level));
      chk("press",   32'(o_press),   32'(m_press));
      chk("release", 32'(o_release), 32'(m_rel));
      chk("repeat",  32'(o_repeat),  32'(m_rpt));
      chk("event",   32'(o_event),   32'(m_evt));
      chk("irq",     32'(o_irq),     32'(m_irq));
      chk("press_and_release", 32'(o_press & o_release), 32'd0);
   endtask

   // Entered and left at a falling edge with inputs already set
   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare();
   endtask

   int p_edge, n_press1;
   int rq[$];

   initial begin
      rst = 1; raw = 4'hF; rpt_en = 0; irq_en = 0; evt_clr = 0;
      @(negedge clk);

      // 1: reset with all buttons released, then idle
      step(); step();
      chk("rst_outputs", 32'({o_level, o_press, o_release, o_repeat, o_event, o_irq}), 32'd0);
      rst = 0;
      repeat (50) step();
      chk("idle_level", 32'(o_level), 32'd0);

      // 2: clean press on channel 0 with latency checks
      irq_en = 4'b0001;
      raw[0] = 1'b0;
      step();                                   // edge k samples the press
      for (int i = 0; i < DEB; i++) begin
         step();
         chk("s2_level_early", 32'(o_level[0]), 32'd0);
      end
      step();                                   // edge k+5
      chk("s2_level", 32'(o_level[0]), 32'd1);
      chk("s2_press", 32'(o_press[0]), 32'd1);
      step();
      chk("s2_press_gone", 32'(o_press[0]), 32'd0);
      chk("s2_event", 32'(o_event[0]), 32'd1);
      step();
      chk("s2_irq", 32'(o_irq), 32'd1);
      repeat (5) step();

      // 3: bounce on channel 1
      n_press1 = 0;
      for (int i = 0; i < 4; i++) begin
         raw[1] = i[0];
         step();
         if (o_press[1]) n_press1++;
      end
      raw[1] = 1'b0;
      repeat (12) begin step(); if (o_press[1]) n_press1++; end
      chk("s3_one_press", 32'(n_press1), 32'd1);

      // 4: auto-repeat on channel 2
      rpt_en[2] = 1'b1;
      raw[2]    = 1'b0;
      p_edge    = -1;
      repeat (45) begin
         step();
         if (o_press[2]) p_edge = edge_n;
         if (o_repeat[2] && p_edge >= 0) rq.push_back(edge_n - p_edge);
      end
      chk("s4_nrep", 32'(rq.size() >= 3), 32'd1);
      if (rq.size() >= 3) begin
         chk("s4_rep0", 32'(rq[0]), 32'(HLD));
         chk("s4_rep1", 32'(rq[1]), 32'(HLD + RPC));
         chk("s4_rep2", 32'(rq[2]), 32'(HLD + 2 * RPC));
      end
      raw[2] = 1'b1;
      repeat (15) step();

      // 5: clear racing a press on channel 3
      irq_en = 4'b1000;
      raw[3] = 1'b0;
      step();
      repeat (DEB) step();
      step();
      chk("s5_press", 32'(o_press[3]), 32'd1);
      evt_clr = 4'b1000;
      step();
      chk("s5_set_wins", 32'(o_event[3]), 32'd1);
      step();
      chk("s5_cleared", 32'(o_event[3]), 32'd0);
      chk("s5_irq_still", 32'(o_irq), 32'd1);
      evt_clr = 4'b0000;
      step();
      chk("s5_irq_drop", 32'(o_irq), 32'd0);

      // 6: reset in the middle of auto-repeat with the button held
      raw[2] = 1'b0;
      repeat (25) step();
      rst = 1;
      step();
      chk("s6_rst_outputs", 32'({o_level, o_press, o_release, o_repeat, o_event, o_irq}), 32'd0);
      rst = 0;
      repeat (5) step();
      chk("s6_no_press_yet", 32'(o_press[2]), 32'd0);
      step();
      chk("s6_press_again", 32'(o_press[2]), 32'd1);
      repeat (HLD - 1) step();
      chk("s6_no_rep_yet", 32'(o_repeat[2]), 32'd0);
      step();
      chk("s6_first_rep", 32'(o_repeat[2]), 32'd1);

      // 7: randomised traffic on all channels
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < NC; c++) begin
            if ($urandom_range(11) == 0) raw[c] = ~raw[c];
            if ($urandom_range(39) == 0) rpt_en[c] = ~rpt_en[c];
            if ($urandom_range(19) == 0) irq_en[c] = ~irq_en[c];
            evt_clr[c] = ($urandom_range(7) == 0);
         end
         rst = ($urandom_range(399) == 0);
         step();
      end
      rst = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
